// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its branch-target table.
package definitions;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam int DEF_INSTR_W = 9;
   localparam int DEF_PC_W    = 10;

   // Bit range of an instruction that selects its branch-table entry
   localparam int BR_IDX_MSB = 5;
   localparam int BR_IDX_LSB = 2;
   localparam int BR_IDX_W   = BR_IDX_MSB - BR_IDX_LSB + 1;

endpackage

// File: rtl/instr_fetch_branch_lut.sv
// Branch-target table: register file with one synchronous write port,
// one combinational read port and an asynchronous active-low clear.
module branch_lut
   import definitions::*;
#(
   parameter int LUT_AW = 4,
   parameter int PC_W   = DEF_PC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [LUT_AW-1:0] waddr,
   input  logic [PC_W-1:0]   wdata,
   input  logic [LUT_AW-1:0] raddr,
   output logic [PC_W-1:0]   rdata
);

   localparam int DEPTH = 1 << LUT_AW;

   logic [PC_W-1:0] entry_reg [DEPTH];
   logic [DEPTH-1:0] hit;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign hit[gi] = we && (waddr == LUT_AW'(gi));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
               entry_reg[i] <= wdata;
            end
         end
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write is not forwarded
   assign rdata = entry_reg[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch and sequencing: owns the PC, registers one instruction per
// cycle onto OPCODE, redirects on taken branches and stops on halt.
module instr_fetch
   import definitions::*;
#(
   parameter int              PC_W     = DEF_PC_W,
   parameter int              INSTR_W  = DEF_INSTR_W,
   parameter int              LUT_AW   = 4,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   output logic [PC_W-1:0]    IMEM_ADDR,
   input  logic [INSTR_W-1:0] IMEM_DATA,
   output logic [INSTR_W-1:0] OPCODE,
   output logic               VALID,
   input  logic               BRANCH,
   input  logic               TAKEN,
   input  logic               HALT,
   input  logic               LUT_WE,
   input  logic [LUT_AW-1:0]  LUT_WADDR,
   input  logic [PC_W-1:0]    LUT_WDATA,
   output logic [PC_W-1:0]    PC,
   output logic               DONE
);

   fetch_state_t        state_reg;
   logic [PC_W-1:0]     pc_reg;
   logic [INSTR_W-1:0]  instr_reg;
   logic                valid_reg;
   logic                done_reg;

   logic [LUT_AW-1:0]   lut_raddr;
   logic [PC_W-1:0]     lut_target;
   logic                halt_fire;
   logic                branch_fire;

   // Decoder flags only mean something when they describe a live instruction
   assign halt_fire   = valid_reg && HALT;
   assign branch_fire = valid_reg && BRANCH && TAKEN;
   assign lut_raddr   = LUT_AW'(instr_reg[BR_IDX_MSB:BR_IDX_LSB]);

   branch_lut #(
      .LUT_AW (LUT_AW),
      .PC_W   (PC_W)
   ) u_branch_lut (
      .clk   (CLK),
      .rst_n (RST_N),
      .we    (LUT_WE),
      .waddr (LUT_WADDR),
      .wdata (LUT_WDATA),
      .raddr (lut_raddr),
      .rdata (lut_target)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         instr_reg <= '0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, HALTED: begin
               if (START) begin
                  state_reg <= RUN;
                  pc_reg    <= START_PC;
                  valid_reg <= 1'b0;
                  done_reg  <= 1'b0;
               end
            end
            RUN: begin
               if (halt_fire) begin
                  // PC stays one past the halt; the fetch in flight is dropped
                  state_reg <= HALTED;
                  valid_reg <= 1'b0;
                  done_reg  <= 1'b1;
               end else if (branch_fire) begin
                  pc_reg    <= lut_target;
                  instr_reg <= IMEM_DATA;
                  valid_reg <= 1'b0;
               end else begin
                  pc_reg    <= pc_reg + PC_W'(1);
                  instr_reg <= IMEM_DATA;
                  valid_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign IMEM_ADDR = pc_reg;
   assign PC        = pc_reg;
   assign OPCODE    = instr_reg;
   assign VALID     = valid_reg;
   assign DONE      = done_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// decoder/table traffic checked against a program-level reference model.
module tb_instr_fetch;

   localparam int PC_W     = 10;
   localparam int INSTR_W  = 9;
   localparam int LUT_AW   = 4;
   localparam int START_PC = 0;
   localparam int IMEM_SZ  = 1 << PC_W;

   logic               CLK = 1'b0;
   logic               RST_N = 1'b0;
   logic               START = 1'b0;
   logic               BRANCH = 1'b0;
   logic               TAKEN = 1'b0;
   logic               HALT = 1'b0;
   logic               LUT_WE = 1'b0;
   logic [LUT_AW-1:0]  LUT_WADDR = '0;
   logic [PC_W-1:0]    LUT_WDATA = '0;
   logic [PC_W-1:0]    IMEM_ADDR;
   logic [INSTR_W-1:0] IMEM_DATA;
   logic [INSTR_W-1:0] OPCODE;
   logic               VALID;
   logic [PC_W-1:0]    PC;
   logic               DONE;

   logic [INSTR_W-1:0] imem [IMEM_SZ];

   int checks = 0;
   int errors = 0;

   // Reference model: architectural view of what the decoder should see
   int                 m_pc;
   logic [INSTR_W-1:0] m_op;
   bit                 m_valid;
   bit                 m_done;
   bit                 m_running;
   int                 m_lut [16];

   instr_fetch #(
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .LUT_AW   (LUT_AW),
      .START_PC (PC_W'(START_PC))
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .START     (START),
      .IMEM_ADDR (IMEM_ADDR),
      .IMEM_DATA (IMEM_DATA),
      .OPCODE    (OPCODE),
      .VALID     (VALID),
      .BRANCH    (BRANCH),
      .TAKEN     (TAKEN),
      .HALT      (HALT),
      .LUT_WE    (LUT_WE),
      .LUT_WADDR (LUT_WADDR),
      .LUT_WDATA (LUT_WDATA),
      .PC        (PC),
      .DONE      (DONE)
   );

   assign IMEM_DATA = imem[IMEM_ADDR];

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string ctx);
      check_eq({ctx, ".pc"},    32'(PC),        32'(m_pc));
      check_eq({ctx, ".iaddr"}, 32'(IMEM_ADDR), 32'(m_pc));
      check_eq({ctx, ".valid"}, 32'(VALID),     32'(m_valid));
      check_eq({ctx, ".done"},  32'(DONE),      32'(m_done));
      if (m_valid) check_eq({ctx, ".op"}, 32'(OPCODE), 32'(m_op));
   endtask

   task automatic model_reset();
      m_pc = 0; m_op = '0; m_valid = 0; m_done = 0; m_running = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 0;
   endtask

   // Called at a negedge: asserts reset mid-cycle and checks the async clear
   task automatic do_reset(input string ctx);
      START = 0; BRANCH = 0; TAKEN = 0; HALT = 0; LUT_WE = 0;
      #2 RST_N = 1'b0;
      #1;
      check_eq({ctx, ".rst_pc"},    32'(PC),        32'h0);
      check_eq({ctx, ".rst_iaddr"}, 32'(IMEM_ADDR), 32'h0);
      check_eq({ctx, ".rst_op"},    32'(OPCODE),    32'h0);
      check_eq({ctx, ".rst_valid"}, 32'(VALID),     32'h0);
      check_eq({ctx, ".rst_done"},  32'(DONE),      32'h0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   // One clock: drive inputs at the negedge, advance the model, check at next negedge
   task automatic step(input bit st, input bit br, input bit tk, input bit hl,
                       input bit we, input int wa, input int wd, input string ctx);
      logic [INSTR_W-1:0] fetched;
      logic [3:0]         idx;
      START = st; BRANCH = br; TAKEN = tk; HALT = hl;
      LUT_WE = we; LUT_WADDR = wa[LUT_AW-1:0]; LUT_WDATA = wd[PC_W-1:0];
      fetched = imem[m_pc];
      idx = m_op[5:2];
      if (!m_running) begin
         if (st) begin
            m_pc = START_PC; m_valid = 0; m_done = 0; m_running = 1;
         end
      end else if (m_valid && hl) begin
         m_running = 0; m_valid = 0; m_done = 1;
      end else if (m_valid && br && tk) begin
         m_pc = m_lut[idx]; m_op = fetched; m_valid = 0;
      end else begin
         m_op = fetched; m_valid = 1; m_pc = (m_pc + 1) % IMEM_SZ;
      end
      if (we) m_lut[wa] = wd;
      @(posedge CLK);
      @(negedge CLK);
      START = 0; BRANCH = 0; TAKEN = 0; HALT = 0; LUT_WE = 0;
      check_model(ctx);
   endtask

   task automatic nop(input string ctx);
      step(0, 0, 0, 0, 0, 0, 0, ctx);
   endtask

   task automatic load_program();
      for (int i = 0; i < IMEM_SZ; i++) imem[i] = INSTR_W'($urandom);
      imem[0] = 9'h101; imem[1] = 9'h102; imem[2] = 9'h14C; imem[3] = 9'h104;
      imem[4] = 9'h105; imem[5] = 9'h106;
      imem[10'h040] = 9'h1AA; imem[10'h041] = 9'h14C; imem[10'h080] = 9'h0F0;
      imem[10'h3FF] = 9'h133;
   endtask

   // START then three fetches: leaves the branch at address 2 on OPCODE
   task automatic start_to_branch(input string ctx);
      step(1, 0, 0, 0, 0, 0, 0, ctx);
      nop(ctx); nop(ctx); nop(ctx);
      check_eq({ctx, ".br_op"}, 32'(OPCODE), 32'h14C);
   endtask

   initial begin
      load_program();
      imem[2] = 9'h103;
      @(negedge CLK);
      do_reset("init");
      check_model("reset");

      // Straight-line fetch
      step(1, 0, 0, 0, 0, 0, 0, "sl");
      check_eq("sl.bubble", 32'(VALID), 32'h0);
      nop("sl"); check_eq("sl.op0", 32'(OPCODE), 32'h101);
      nop("sl"); check_eq("sl.op1", 32'(OPCODE), 32'h102);
      nop("sl"); check_eq("sl.op2", 32'(OPCODE), 32'h103);
      nop("sl"); check_eq("sl.op3", 32'(OPCODE), 32'h104);
      check_eq("sl.v3", 32'(VALID), 32'h1);
      $display("txn straight_line checks=%0d errors=%0d", checks, errors);

      // Taken branch
      load_program();
      do_reset("tk");
      step(0, 0, 0, 0, 1, 3, 10'h040, "tk");
      start_to_branch("tk");
      step(0, 1, 1, 0, 0, 0, 0, "tk");
      check_eq("tk.bubble", 32'(VALID), 32'h0);
      check_eq("tk.pc", 32'(PC), 32'h040);
      nop("tk");
      check_eq("tk.target_op", 32'(OPCODE), 32'h1AA);
      check_eq("tk.target_v", 32'(VALID), 32'h1);
      $display("txn taken_branch checks=%0d errors=%0d", checks, errors);

      // Not-taken branch
      do_reset("nt");
      step(0, 0, 0, 0, 1, 3, 10'h040, "nt");
      start_to_branch("nt");
      step(0, 1, 0, 0, 0, 0, 0, "nt");
      check_eq("nt.op", 32'(OPCODE), 32'h104);
      check_eq("nt.v", 32'(VALID), 32'h1);
      $display("txn not_taken_branch checks=%0d errors=%0d", checks, errors);

      // Halt at address 5, then restart
      do_reset("hl");
      step(1, 0, 0, 0, 0, 0, 0, "hl");
      for (int i = 0; i < 6; i++) nop("hl");
      check_eq("hl.op5", 32'(OPCODE), 32'h106);
      step(0, 0, 0, 1, 0, 0, 0, "hl");
      check_eq("hl.done", 32'(DONE), 32'h1);
      check_eq("hl.pc", 32'(PC), 32'h6);
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 1, 1, 0, 0, 0, "hl_idle");
         check_eq("hl.quiet", 32'(VALID), 32'h0);
      end
      step(1, 0, 0, 0, 0, 0, 0, "hl_rs");
      check_eq("hl.rs_done", 32'(DONE), 32'h0);
      check_eq("hl.rs_pc", 32'(PC), 32'(START_PC));
      nop("hl_rs");
      check_eq("hl.rs_op", 32'(OPCODE), 32'h101);
      $display("txn halt_restart checks=%0d errors=%0d", checks, errors);

      // Table write in the same cycle a branch reads the same entry
      do_reset("lw");
      step(0, 0, 0, 0, 1, 3, 10'h040, "lw");
      start_to_branch("lw");
      step(0, 1, 1, 0, 1, 3, 10'h080, "lw");
      check_eq("lw.old_pc", 32'(PC), 32'h040);
      nop("lw"); nop("lw");
      check_eq("lw.br2_op", 32'(OPCODE), 32'h14C);
      step(0, 1, 1, 0, 0, 0, 0, "lw");
      check_eq("lw.new_pc", 32'(PC), 32'h080);
      nop("lw");
      check_eq("lw.new_op", 32'(OPCODE), 32'h0F0);
      $display("txn lut_same_cycle checks=%0d errors=%0d", checks, errors);

      // PC wrap 1023 -> 0
      do_reset("wr");
      step(0, 0, 0, 0, 1, 3, 10'h3FF, "wr");
      start_to_branch("wr");
      step(0, 1, 1, 0, 0, 0, 0, "wr");
      check_eq("wr.pc_top", 32'(PC), 32'h3FF);
      nop("wr");
      check_eq("wr.pc_wrap", 32'(PC), 32'h0);
      check_eq("wr.op", 32'(OPCODE), 32'h133);
      nop("wr");
      check_eq("wr.op0", 32'(OPCODE), 32'h101);
      $display("txn pc_wrap checks=%0d errors=%0d", checks, errors);

      // Reset mid-run clears the table too
      do_reset("mr");
      step(0, 0, 0, 0, 1, 3, 10'h040, "mr");
      start_to_branch("mr");
      do_reset("mr");
      start_to_branch("mr2");
      step(0, 1, 1, 0, 0, 0, 0, "mr2");
      check_eq("mr.lut_cleared", 32'(PC), 32'h0);
      $display("txn reset_mid_run checks=%0d errors=%0d", checks, errors);

      // Randomized decoder and table traffic
      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < IMEM_SZ; i++) imem[i] = INSTR_W'($urandom);
         do_reset("rnd");
         for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 40) == 0,
                 $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, IMEM_SZ - 1)),
                 "rnd");
         end
         $display("txn random_block %0d checks=%0d errors=%0d", blk, checks, errors);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and sequencing unit for the 9-bit core. It owns the program counter, reads the external instruction memory, and registers one instruction per cycle onto the `OPCODE` bus that the control decoder consumes. It closes the loop on the decoder's `BRANCH` and `HALT` outputs: it redirects the PC through a programmable branch-target table, squashes the wrong-path instruction, and stops the core on halt. It sits between instruction memory and the decoder/register-file stage.

## Interface
- `PC_W`, 10: program counter and instruction-memory address width.
- `INSTR_W`, 9: instruction width.
- `LUT_AW`, 4: branch-target table index width (16 entries).
- `START_PC`, 0: PC value loaded on `START`.

Ports:
- `CLK` in 1: the single clock; all state updates on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: begin execution; honoured only in IDLE or HALTED.
- `IMEM_ADDR` out PC_W: instruction memory address, equal to the current PC.
- `IMEM_DATA` in INSTR_W: instruction word, combinational read of `IMEM_ADDR`.
- `OPCODE` out INSTR_W: registered instruction, driven to the decoder.
- `VALID` out 1: `OPCODE` holds a live instruction; downstream gates all writes with it.
- `BRANCH` in 1: decoder flags `OPCODE` as a branch.
- `TAKEN` in 1: branch condition true (from the ALU), same cycle as `BRANCH`.
- `HALT` in 1: decoder flags `OPCODE` as halt.
- `LUT_WE` in 1: branch-table write enable.
- `LUT_WADDR` in LUT_AW: table write index.
- `LUT_WDATA` in PC_W: target address to store.
- `PC` out PC_W: current PC, for debug.
- `DONE` out 1: core halted; high in HALTED.

## Operation
- FSM states: IDLE, RUN, HALTED. The reset state is IDLE.
- IDLE or HALTED with `START`=1: load PC←`START_PC`, clear `VALID`, and clear `DONE`. Next state is RUN.
- RUN, normal cycle: `INSTR_Q`←`IMEM_DATA`, `VALID`←1, PC←PC+1.
  - The PC increment wraps modulo 2^PC_W.
- RUN with `VALID`&`BRANCH`&`TAKEN`: PC←LUT[`OPCODE[5:2]`], `INSTR_Q`←`IMEM_DATA`, `VALID`←0. This squashes the wrong-path fetch.
- RUN with `VALID`&`BRANCH`&!`TAKEN`: treated as a normal cycle.
- RUN with `VALID`&`HALT`:
  - Next state is HALTED, `VALID`←0, `DONE`←1.
  - PC holds, ending at halt address + 1.
  - `HALT` has priority over `BRANCH`.
- `BRANCH`/`HALT` with `VALID`=0 are ignored, since they come from a bubble.
- `START` while in RUN is ignored.
- LUT write: entry[`LUT_WADDR`]←`LUT_WDATA` on the edge, accepted in every state.
  - When a branch reads the same entry in the same cycle, the branch uses the old value.
- `OPCODE` = `INSTR_Q`. It keeps its last value while `VALID`=0; consumers must ignore it then.

## Timing
- Reset values: PC=0, `OPCODE`=0, `VALID`=0, `DONE`=0, state IDLE, all LUT entries 0.
  - `IMEM_ADDR` follows PC, so it is 0 during reset.
- `RST_N` low at any point, including mid-RUN, forces the reset values asynchronously. The core waits for a new `START`.
- Start latency:
  - `START` sampled at edge s.
  - Instruction at `START_PC` is fetched in cycle s+1.
  - That instruction is on `OPCODE` with `VALID`=1 in cycle s+2.
- Fetch latency: one cycle. The instruction at PC p is fetched in cycle t and presented in t+1.
- Taken-branch penalty: exactly one bubble.
  - The branch is on `OPCODE` in cycle t+1.
  - Cycle t+2 is a bubble (`VALID`=0).
  - The target instruction is valid in cycle t+3.
- Halt: `DONE` rises on the edge after the cycle with a valid `HALT`. No instruction after the halt ever presents `VALID`=1.
- `BRANCH`, `TAKEN` and `HALT` are sampled only at the rising edge. Combinational glitches within a cycle are harmless.

## Structure
- The shared `definitions` package holds:
  - `fetch_state_t` enum {IDLE, RUN, HALTED};
  - the constants `INSTR_W` and `PC_W` defaults;
  - the `BR_IDX_MSB`/`BR_IDX_LSB` constants (5/2), which locate the branch-table index in the instruction.
- Sub-module `branch_lut`:
  - 2^LUT_AW × PC_W register file;
  - one synchronous write port and one combinational read port;
  - asynchronous active-low clear.
- PC, instruction register and FSM live in `instr_fetch` itself.

## Test plan
- Straight line: reset, IMEM[0..3]=9'h101..9'h104, pulse `START`.
  - Cycles s+2..s+5 show `OPCODE`=101,102,103,104, all with `VALID`=1.
- Taken branch:
  - Setup: LUT[3]=10'h040; IMEM[2]=9'h14C (`OPCODE[5:2]`=3); force `BRANCH`=`TAKEN`=1 while it is valid.
  - Expect: one bubble, then `OPCODE`=IMEM[0x40] with `VALID`=1. IMEM[3] is never valid.
- Not-taken branch: same program with `TAKEN`=0.
  - IMEM[3] follows immediately with no bubble.
- Halt and restart: `HALT`=1 on the instruction at address 5.
  - Expect `DONE`=1 and PC=6 on the next edge. `VALID` stays 0 for 10 cycles.
  - A new `START` gives `DONE`=0 and refetches from `START_PC`.
- Edge cases:
  - LUT write to entry 3 (10'h080) in the same cycle a branch uses entry 3: the branch goes to 10'h040. The next branch to entry 3 goes to 10'h080.
  - PC wrap: 1023 → 0.
  - `RST_N` asserted mid-RUN: outputs return immediately to the reset values, the state returns to IDLE, and LUT entries clear to 0.
